// File: rtl/axi_lite_to_obi_bridge.sv
// AXI4-Lite subordinate that replays each access as a single OBI manager transaction.
// One transaction in flight; AW/W/AR are buffered in holding registers until served.
module axi_lite_to_obi_bridge #(
   parameter  int unsigned AddrWidth = 32,
   parameter  int unsigned DataWidth = 32,
   localparam int unsigned StrbWidth = DataWidth / 8
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [AddrWidth-1:0] aw_addr_i,
   input  logic                 aw_valid_i,
   output logic                 aw_ready_o,
   input  logic [DataWidth-1:0] w_data_i,
   input  logic [StrbWidth-1:0] w_strb_i,
   input  logic                 w_valid_i,
   output logic                 w_ready_o,
   output logic [1:0]           b_resp_o,
   output logic                 b_valid_o,
   input  logic                 b_ready_i,
   input  logic [AddrWidth-1:0] ar_addr_i,
   input  logic                 ar_valid_i,
   output logic                 ar_ready_o,
   output logic [DataWidth-1:0] r_data_o,
   output logic [1:0]           r_resp_o,
   output logic                 r_valid_o,
   input  logic                 r_ready_i,
   output logic                 obi_req_o,
   output logic [AddrWidth-1:0] obi_addr_o,
   output logic                 obi_we_o,
   output logic [StrbWidth-1:0] obi_be_o,
   output logic [DataWidth-1:0] obi_wdata_o,
   input  logic                 obi_gnt_i,
   input  logic                 obi_rvalid_i,
   input  logic [DataWidth-1:0] obi_rdata_i,
   input  logic                 obi_err_i
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WR_REQ  = 3'd1;
   localparam logic [2:0] S_WR_WAIT = 3'd2;
   localparam logic [2:0] S_WR_RESP = 3'd3;
   localparam logic [2:0] S_RD_REQ  = 3'd4;
   localparam logic [2:0] S_RD_WAIT = 3'd5;
   localparam logic [2:0] S_RD_RESP = 3'd6;

   localparam logic [AddrWidth-1:0] AddrMask = ~AddrWidth'(StrbWidth - 1);

   logic [2:0]           r_state;
   logic [2:0]           w_state_nxt;
   logic                 r_out_en;
   logic                 r_aw_full;
   logic                 r_w_full;
   logic                 r_ar_full;
   logic                 r_prio_rd;
   logic                 r_err;
   logic [AddrWidth-1:0] r_aw_addr;
   logic [AddrWidth-1:0] r_ar_addr;
   logic [DataWidth-1:0] r_wdata;
   logic [StrbWidth-1:0] r_wstrb;
   logic [DataWidth-1:0] r_rdata;

   logic w_aw_hs;
   logic w_w_hs;
   logic w_ar_hs;
   logic w_b_hs;
   logic w_r_hs;
   logic w_wr_rdy;
   logic w_rd_rdy;
   logic w_in_wait;

   // r_out_en keeps every ready low while reset is asserted and releases them one cycle later
   assign aw_ready_o = r_out_en & ~r_aw_full;
   assign w_ready_o  = r_out_en & ~r_w_full;
   assign ar_ready_o = r_out_en & (r_state == S_IDLE) & ~r_ar_full & ~(r_aw_full & r_w_full);

   assign w_aw_hs   = aw_valid_i & aw_ready_o;
   assign w_w_hs    = w_valid_i & w_ready_o;
   assign w_ar_hs   = ar_valid_i & ar_ready_o;
   assign w_b_hs    = b_valid_o & b_ready_i;
   assign w_r_hs    = r_valid_o & r_ready_i;
   assign w_wr_rdy  = r_aw_full & r_w_full;
   assign w_rd_rdy  = r_ar_full;
   assign w_in_wait = (r_state == S_WR_WAIT) | (r_state == S_RD_WAIT);

   assign b_valid_o = (r_state == S_WR_RESP);
   assign b_resp_o  = b_valid_o ? {r_err, 1'b0} : '0;
   assign r_valid_o = (r_state == S_RD_RESP);
   assign r_resp_o  = r_valid_o ? {r_err, 1'b0} : '0;
   assign r_data_o  = r_valid_o ? r_rdata : '0;

   assign obi_req_o   = (r_state == S_WR_REQ) | (r_state == S_RD_REQ);
   assign obi_we_o    = (r_state == S_WR_REQ);
   assign obi_addr_o  = (r_state == S_WR_REQ) ? (r_aw_addr & AddrMask) :
                        (r_state == S_RD_REQ) ? (r_ar_addr & AddrMask) : '0;
   assign obi_be_o    = (r_state == S_WR_REQ) ? r_wstrb :
                        (r_state == S_RD_REQ) ? '1 : '0;
   assign obi_wdata_o = (r_state == S_WR_REQ) ? r_wdata : '0;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            // r_prio_rd set means the write side was served last, so a pending read goes first
            if (w_wr_rdy && (!w_rd_rdy || !r_prio_rd)) begin
               w_state_nxt = (r_wstrb == '0) ? S_WR_RESP : S_WR_REQ;
            end else if (w_rd_rdy) begin
               w_state_nxt = S_RD_REQ;
            end
         end
         S_WR_REQ:  if (obi_gnt_i)    w_state_nxt = S_WR_WAIT;
         S_WR_WAIT: if (obi_rvalid_i) w_state_nxt = S_WR_RESP;
         S_WR_RESP: if (b_ready_i)    w_state_nxt = S_IDLE;
         S_RD_REQ:  if (obi_gnt_i)    w_state_nxt = S_RD_WAIT;
         S_RD_WAIT: if (obi_rvalid_i) w_state_nxt = S_RD_RESP;
         S_RD_RESP: if (r_ready_i)    w_state_nxt = S_IDLE;
         default:                     w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state   <= S_IDLE;
         r_out_en  <= 1'b0;
         r_aw_full <= 1'b0;
         r_w_full  <= 1'b0;
         r_ar_full <= 1'b0;
         r_prio_rd <= 1'b0;
         r_err     <= 1'b0;
         r_aw_addr <= '0;
         r_ar_addr <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_rdata   <= '0;
      end else begin
         r_out_en <= 1'b1;
         r_state  <= w_state_nxt;

         if (w_b_hs) begin
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
         end else begin
            if (w_aw_hs) begin
               r_aw_full <= 1'b1;
               r_aw_addr <= aw_addr_i;
            end
            if (w_w_hs) begin
               r_w_full <= 1'b1;
               r_wdata  <= w_data_i;
               r_wstrb  <= w_strb_i;
            end
         end

         if (w_r_hs) begin
            r_ar_full <= 1'b0;
         end else if (w_ar_hs) begin
            r_ar_full <= 1'b1;
            r_ar_addr <= ar_addr_i;
         end

         if (w_b_hs) begin
            r_prio_rd <= 1'b1;
         end else if (w_r_hs) begin
            r_prio_rd <= 1'b0;
         end

         // clearing in IDLE gives the zero-strobe write path its OKAY response
         if (r_state == S_IDLE) begin
            r_err <= 1'b0;
         end else if (w_in_wait && obi_rvalid_i) begin
            r_err   <= obi_err_i;
            r_rdata <= obi_rdata_i;
         end
      end
   end

endmodule

// File: tb/tb_axi_lite_to_obi_bridge.sv
// Bench for axi_lite_to_obi_bridge: directed scenarios plus randomized traffic
// checked against a word-memory reference model behind an OBI slave model.
module tb_axi_lite_to_obi_bridge;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } obi_txn_t;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic [31:0] aw_addr_i;
   logic        aw_valid_i;
   logic        aw_ready_o;
   logic [31:0] w_data_i;
   logic [3:0]  w_strb_i;
   logic        w_valid_i;
   logic        w_ready_o;
   logic [1:0]  b_resp_o;
   logic        b_valid_o;
   logic        b_ready_i;
   logic [31:0] ar_addr_i;
   logic        ar_valid_i;
   logic        ar_ready_o;
   logic [31:0] r_data_o;
   logic [1:0]  r_resp_o;
   logic        r_valid_o;
   logic        r_ready_i;
   logic        obi_req_o;
   logic [31:0] obi_addr_o;
   logic        obi_we_o;
   logic [3:0]  obi_be_o;
   logic [31:0] obi_wdata_o;
   logic        obi_gnt_i;
   logic        obi_rvalid_i;
   logic [31:0] obi_rdata_i;
   logic        obi_err_i;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   int          gnt_dly = 0;
   int          rv_dly  = 1;
   bit          ovr_en  = 1'b0;
   logic [31:0] ovr_rdata = '0;
   bit          ovr_err = 1'b0;
   int          last_req_cyc = 0;

   obi_txn_t    log_q[$];
   logic [31:0] slv_mem [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];

   logic w_any_out;
   assign w_any_out = |{aw_ready_o, w_ready_o, b_resp_o, b_valid_o, ar_ready_o, r_data_o,
                        r_resp_o, r_valid_o, obi_req_o, obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o};

   axi_lite_to_obi_bridge #(.AddrWidth(32), .DataWidth(32)) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .aw_addr_i(aw_addr_i), .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o),
      .w_data_i(w_data_i), .w_strb_i(w_strb_i), .w_valid_i(w_valid_i), .w_ready_o(w_ready_o),
      .b_resp_o(b_resp_o), .b_valid_o(b_valid_o), .b_ready_i(b_ready_i),
      .ar_addr_i(ar_addr_i), .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o),
      .r_data_o(r_data_o), .r_resp_o(r_resp_o), .r_valid_o(r_valid_o), .r_ready_i(r_ready_i),
      .obi_req_o(obi_req_o), .obi_addr_o(obi_addr_o), .obi_we_o(obi_we_o), .obi_be_o(obi_be_o),
      .obi_wdata_o(obi_wdata_o), .obi_gnt_i(obi_gnt_i), .obi_rvalid_i(obi_rvalid_i),
      .obi_rdata_i(obi_rdata_i), .obi_err_i(obi_err_i)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
   endfunction

   function automatic bit err_rule(input logic [31:0] a);
      return a[11:8] == 4'hF;
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
   endfunction

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // OBI slave: grants after gnt_dly request cycles, answers rv_dly cycles after the grant
   initial begin : obi_slave
      int          wait_cnt;
      int          rv_cnt;
      int          req_cyc;
      bit          pend;
      logic [31:0] p_rdata;
      bit          p_err;
      obi_txn_t    cur;
      obi_txn_t    first;
      logic [31:0] w;
      wait_cnt = 0; rv_cnt = 0; req_cyc = 0; pend = 1'b0; p_rdata = '0; p_err = 1'b0;
      obi_gnt_i = 1'b0; obi_rvalid_i = 1'b0; obi_rdata_i = '0; obi_err_i = 1'b0;
      forever begin
         @(negedge clk);
         obi_gnt_i    = 1'b0;
         obi_rvalid_i = 1'b0;
         obi_err_i    = 1'b0;
         obi_rdata_i  = $urandom;
         if (!rst_ni) begin
            pend = 1'b0; wait_cnt = 0; req_cyc = 0;
         end else if (pend) begin
            if (rv_cnt == 0) begin
               obi_rvalid_i = 1'b1;
               obi_rdata_i  = p_rdata;
               obi_err_i    = p_err;
               pend         = 1'b0;
            end else begin
               rv_cnt--;
            end
         end else if (obi_req_o) begin
            req_cyc++;
            cur.we = obi_we_o; cur.addr = obi_addr_o; cur.be = obi_be_o; cur.wdata = obi_wdata_o;
            if (wait_cnt == 0) begin
               first = cur;
            end else begin
               check_eq("obi_stable_ctl", {cur.we, cur.be, cur.addr}, {first.we, first.be, first.addr});
               check_eq("obi_stable_wdata", cur.wdata, first.wdata);
            end
            if (wait_cnt >= gnt_dly) begin
               obi_gnt_i = 1'b1;
               p_err = ovr_en ? ovr_err : err_rule(cur.addr);
               if (cur.we) begin
                  if (!p_err) begin
                     w = slv_mem.exists(cur.addr) ? slv_mem[cur.addr] : init_word(cur.addr);
                     for (int i = 0; i < 4; i++) if (cur.be[i]) w[8*i +: 8] = cur.wdata[8*i +: 8];
                     slv_mem[cur.addr] = w;
                  end
                  p_rdata = $urandom;
               end else begin
                  p_rdata = ovr_en ? ovr_rdata :
                            (slv_mem.exists(cur.addr) ? slv_mem[cur.addr] : init_word(cur.addr));
               end
               log_q.push_back(cur);
               pend = 1'b1;
               rv_cnt = rv_dly - 1;
               wait_cnt = 0;
               last_req_cyc = req_cyc;
               req_cyc = 0;
            end else begin
               wait_cnt++;
            end
         end
      end
   end

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int rdy_dly,
                            output logic [1:0] resp, output int lat);
      int t;
      int hs_cyc;
      bit aw_done, w_done, hs_aw, hs_w;
      t = 0; hs_cyc = 0; aw_done = 1'b0; w_done = 1'b0; resp = '0; lat = -1;
      while (!(aw_done && w_done) && t < 40) begin
         aw_addr_i  = addr;
         w_data_i   = data;
         w_strb_i   = strb;
         aw_valid_i = !aw_done && (t >= aw_dly);
         w_valid_i  = !w_done && (t >= w_dly);
         hs_aw = aw_valid_i && aw_ready_o;
         hs_w  = w_valid_i && w_ready_o;
         if (hs_aw || hs_w) hs_cyc = cyc;
         @(negedge clk);
         t++;
         if (hs_aw) aw_done = 1'b1;
         if (hs_w)  w_done  = 1'b1;
      end
      aw_valid_i = 1'b0;
      w_valid_i  = 1'b0;
      if (!(aw_done && w_done)) begin
         check_eq("wr_accept_timeout", 0, 1);
         return;
      end
      t = 0;
      while (!b_valid_o && t < 40) begin
         @(negedge clk);
         t++;
      end
      if (!b_valid_o) begin
         check_eq("b_valid_timeout", 0, 1);
         return;
      end
      lat  = cyc - hs_cyc;
      resp = b_resp_o;
      for (int i = 0; i < rdy_dly; i++) begin
         @(negedge clk);
         check_eq("b_hold", {b_valid_o, b_resp_o}, {1'b1, resp});
      end
      b_ready_i = 1'b1;
      @(negedge clk);
      b_ready_i = 1'b0;
      check_eq("b_drop", b_valid_o, 0);
   endtask

   task automatic axi_read(input logic [31:0] addr, input int ar_dly, input int rdy_dly,
                           output logic [31:0] data, output logic [1:0] resp, output int lat);
      int t;
      int hs_cyc;
      bit done;
      t = 0; hs_cyc = 0; done = 1'b0; data = '0; resp = '0; lat = -1;
      while (!done && t < 40) begin
         ar_addr_i  = addr;
         ar_valid_i = (t >= ar_dly);
         if (ar_valid_i && ar_ready_o) begin
            done = 1'b1;
            hs_cyc = cyc;
         end
         @(negedge clk);
         t++;
      end
      ar_valid_i = 1'b0;
      if (!done) begin
         check_eq("ar_accept_timeout", 0, 1);
         return;
      end
      t = 0;
      while (!r_valid_o && t < 40) begin
         @(negedge clk);
         t++;
      end
      if (!r_valid_o) begin
         check_eq("r_valid_timeout", 0, 1);
         return;
      end
      lat  = cyc - hs_cyc;
      resp = r_resp_o;
      data = r_data_o;
      for (int i = 0; i < rdy_dly; i++) begin
         @(negedge clk);
         check_eq("r_hold", {r_valid_o, r_resp_o, r_data_o}, {1'b1, resp, data});
         check_eq("ar_ready_blocked", ar_ready_o, 0);
      end
      r_ready_i = 1'b1;
      @(negedge clk);
      r_ready_i = 1'b0;
      check_eq("r_drop", r_valid_o, 0);
   endtask

   task automatic pair_round(input logic [31:0] wa, input logic [31:0] ra);
      int nb, nr, t;
      aw_addr_i = wa; w_data_i = $urandom; w_strb_i = 4'hF; ar_addr_i = ra;
      aw_valid_i = 1'b1; w_valid_i = 1'b1; ar_valid_i = 1'b1;
      check_eq("rr_accept", {aw_ready_o, w_ready_o, ar_ready_o}, 3'b111);
      @(negedge clk);
      aw_valid_i = 1'b0; w_valid_i = 1'b0; ar_valid_i = 1'b0;
      b_ready_i = 1'b1; r_ready_i = 1'b1;
      nb = 0; nr = 0; t = 0;
      while ((nb == 0 || nr == 0) && t < 40) begin
         if (b_valid_o) nb++;
         if (r_valid_o) nr++;
         @(negedge clk);
         t++;
      end
      b_ready_i = 1'b0; r_ready_i = 1'b0;
      check_eq("rr_b_count", nb, 1);
      check_eq("rr_r_count", nr, 1);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : main
      logic [1:0]  resp;
      logic [31:0] rd;
      int          lat;
      int          base;
      int          seen;
      obi_txn_t    e;
      bit          exp_we [7];

      rst_ni = 1'b0;
      aw_addr_i = '0; aw_valid_i = 1'b0; w_data_i = '0; w_strb_i = '0; w_valid_i = 1'b0;
      b_ready_i = 1'b0; ar_addr_i = '0; ar_valid_i = 1'b0; r_ready_i = 1'b0;

      repeat (3) @(negedge clk);
      check_eq("reset_outs_zero", w_any_out, 0);
      #2 rst_ni = 1'b1;
      @(negedge clk);
      check_eq("reset_readies", {aw_ready_o, w_ready_o, ar_ready_o}, 3'b111);

      // 1: AW and W together, immediate grant
      gnt_dly = 0; rv_dly = 1; base = log_q.size();
      axi_write(32'h1000_0006, 32'hDEAD_BEEF, 4'hC, 0, 0, 0, resp, lat);
      check_eq("t1_obi_count", log_q.size() - base, 1);
      if (log_q.size() > base) begin
         e = log_q[base];
         check_eq("t1_obi_addr", e.addr, 32'h1000_0004);
         check_eq("t1_obi_be", e.be, 4'hC);
         check_eq("t1_obi_we", e.we, 1);
         check_eq("t1_obi_wdata", e.wdata, 32'hDEAD_BEEF);
      end
      check_eq("t1_b_latency", lat, 4);
      check_eq("t1_b_resp", resp, 2'b00);

      // 2: W leads AW by two cycles, grant delayed three cycles
      gnt_dly = 3; base = log_q.size();
      axi_write(32'h0000_0020, 32'hA5A5_0F0F, 4'hF, 2, 0, 0, resp, lat);
      check_eq("t2_obi_count", log_q.size() - base, 1);
      check_eq("t2_req_cycles", last_req_cyc, 4);
      check_eq("t2_b_latency", lat, 7);
      check_eq("t2_b_resp", resp, 2'b00);
      seen = 0;
      repeat (5) begin
         @(negedge clk);
         if (b_valid_o) seen++;
      end
      check_eq("t2_single_b", seen, 0);
      gnt_dly = 0;

      // 3: read with error and stalled R
      ovr_en = 1'b1; ovr_rdata = 32'h1234_5678; ovr_err = 1'b1; base = log_q.size();
      axi_read(32'h0000_0040, 0, 5, rd, resp, lat);
      ovr_en = 1'b0;
      check_eq("t3_r_data", rd, 32'h1234_5678);
      check_eq("t3_r_resp", resp, 2'b10);
      check_eq("t3_r_latency", lat, 4);
      if (log_q.size() == base + 1) begin
         e = log_q[base];
         check_eq("t3_obi_rd", {e.we, e.be, e.addr}, {1'b0, 4'hF, 32'h0000_0040});
      end else begin
         check_eq("t3_obi_count", log_q.size() - base, 1);
      end

      // 5: zero-strobe write never reaches OBI
      base = log_q.size();
      axi_write(32'h0000_0080, 32'h1111_1111, 4'h0, 0, 0, 0, resp, lat);
      check_eq("t5_no_obi", log_q.size() - base, 0);
      check_eq("t5_b_latency", lat, 2);
      check_eq("t5_b_resp", resp, 2'b00);

      // 6: reset while waiting for the OBI response
      gnt_dly = 0; rv_dly = 6; base = log_q.size();
      aw_addr_i = 32'h0000_0500; w_data_i = 32'hCAFE_F00D; w_strb_i = 4'hF;
      aw_valid_i = 1'b1; w_valid_i = 1'b1;
      check_eq("t6_accept", {aw_ready_o, w_ready_o}, 2'b11);
      @(negedge clk);
      aw_valid_i = 1'b0; w_valid_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2;
      check_eq("t6_granted", log_q.size() - base, 1);
      rst_ni = 1'b0;
      #1;
      check_eq("t6_rst_outs_now", w_any_out, 0);
      repeat (2) @(negedge clk);
      check_eq("t6_rst_outs_held", w_any_out, 0);
      #2 rst_ni = 1'b1;
      @(negedge clk);
      check_eq("t6_ready_after", {aw_ready_o, w_ready_o}, 2'b11);
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (b_valid_o || r_valid_o || obi_req_o) seen++;
      end
      check_eq("t6_no_stale", seen, 0);
      rv_dly = 1;

      // 4: round-robin between held write and read (write wins after reset)
      base = log_q.size();
      pair_round(32'h0000_0300, 32'h0000_0304);
      pair_round(32'h0000_0308, 32'h0000_030C);
      axi_write(32'h0000_0310, 32'h0000_0001, 4'hF, 0, 0, 0, resp, lat);
      pair_round(32'h0000_0314, 32'h0000_0318);
      exp_we = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      check_eq("t4_obi_count", log_q.size() - base, 7);
      for (int i = 0; i < 7; i++) begin
         if (base + i < log_q.size()) check_eq($sformatf("t4_order_%0d", i), log_q[base + i].we, exp_we[i]);
      end

      // randomized traffic against the word-memory reference
      for (int k = 0; k < 60; k++) begin
         logic [31:0] a, d;
         logic [3:0]  s, page;
         int          sel;
         bit          err;
         sel  = $urandom_range(0, 3);
         page = (sel == 3) ? 4'hF : 4'(sel);
         a    = {20'h0, page, 8'h0} | 32'($urandom_range(0, 31));
         gnt_dly = $urandom_range(0, 3);
         rv_dly  = $urandom_range(1, 3);
         base = log_q.size();
         if ($urandom_range(0, 1) == 1) begin
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            axi_write(a, d, s, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 3), resp, lat);
            err = (s != 4'h0) && err_rule(a);
            check_eq("rnd_b_resp", resp, err ? 2'b10 : 2'b00);
            if (s == 4'h0) begin
               check_eq("rnd_b_latency", lat, 2);
               check_eq("rnd_wr_no_obi", log_q.size() - base, 0);
            end else begin
               check_eq("rnd_b_latency", lat, 3 + gnt_dly + rv_dly);
               check_eq("rnd_wr_obi_count", log_q.size() - base, 1);
               if (log_q.size() == base + 1) begin
                  e = log_q[base];
                  check_eq("rnd_wr_obi_ctl", {e.we, e.be, e.addr}, {1'b1, s, a & ~32'h3});
                  check_eq("rnd_wr_obi_wdata", e.wdata, d);
               end
               if (!err) begin
                  logic [31:0] w;
                  w = ref_rd(a & ~32'h3);
                  for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
                  ref_mem[a & ~32'h3] = w;
               end
            end
         end else begin
            axi_read(a, $urandom_range(0, 2), $urandom_range(0, 3), rd, resp, lat);
            err = err_rule(a);
            check_eq("rnd_r_resp", resp, err ? 2'b10 : 2'b00);
            check_eq("rnd_r_latency", lat, 3 + gnt_dly + rv_dly);
            if (!err) check_eq("rnd_r_data", rd, ref_rd(a & ~32'h3));
            check_eq("rnd_rd_obi_count", log_q.size() - base, 1);
            if (log_q.size() == base + 1) begin
               e = log_q[base];
               check_eq("rnd_rd_obi_ctl", {e.we, e.be, e.addr}, {1'b0, 4'hF, a & ~32'h3});
            end
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
